// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the MEM stage (master) and dmem_responder (slave).
// misalign_err exists only when DMEM_MISALIGN_TRAP_EN is defined.
interface dmem_responder_if;
    logic        req;
    logic        write;
    logic        byte_en;
    logic [15:0] address;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        ack;
    logic        stall;
    logic        busy;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        misalign_err;

    modport master (
        output req, write, byte_en, address, write_data,
        input  read_data, ack, stall, busy, misalign_err
    );
    modport slave (
        input  req, write, byte_en, address, write_data,
        output read_data, ack, stall, busy, misalign_err
    );
`else
    modport master (
        output req, write, byte_en, address, write_data,
        input  read_data, ack, stall, busy
    );
    modport slave (
        input  req, write, byte_en, address, write_data,
        output read_data, ack, stall, busy
    );
`endif
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle 16-bit data memory responder with word/byte access and pipeline stall output.
// Optional DMEM_MISALIGN_TRAP_EN flags odd-address word accesses via misalign_err.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input logic             clock,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, be_q;
    logic [15:0]   addr_q, wdata_q;
    logic [15:0]   rdata_q, rdata_d;
    logic          err_q;
    logic [15:0]   mem [DEPTH_WORDS];

    logic          accept, enter_resp, commit_we;
    logic          acc_wr, acc_be, mis, in_range, drop;
    logic [15:0]   acc_addr, acc_wdata;
    logic [14:0]   acc_idx;
    logic [AW-1:0] mem_idx;
    logic [15:0]   cur_word, new_word;
    logic [7:0]    cur_byte;

    assign accept = (state_q == StIdle) && bus.req;

    // Live inputs are used while idle so that LATENCY = 1 can commit on the accept edge.
    always_comb begin
        acc_wr    = (state_q == StIdle) ? bus.write      : wr_q;
        acc_be    = (state_q == StIdle) ? bus.byte_en    : be_q;
        acc_addr  = (state_q == StIdle) ? bus.address    : addr_q;
        acc_wdata = (state_q == StIdle) ? bus.write_data : wdata_q;
        acc_idx   = acc_addr[15:1];
        in_range  = 32'(acc_idx) < DEPTH_WORDS;
        mem_idx   = acc_idx[AW-1:0];
        cur_word  = mem[mem_idx];
        cur_byte  = acc_addr[0] ? cur_word[15:8] : cur_word[7:0];
`ifdef DMEM_MISALIGN_TRAP_EN
        mis       = ~acc_be & acc_addr[0];
`else
        mis       = 1'b0;
`endif
        drop      = ~in_range | mis;
        new_word  = acc_wdata;
        if (acc_be) begin
            new_word = acc_addr[0] ? {acc_wdata[7:0], cur_word[7:0]}
                                   : {cur_word[15:8], acc_wdata[7:0]};
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    state_d = (LATENCY == 1) ? StResp : StWait;
                    cnt_d   = CW'(LATENCY - 1);
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign enter_resp = (state_d == StResp) && (state_q != StResp);
    assign commit_we  = enter_resp & acc_wr & ~drop & ~reset;

    always_comb begin
        rdata_d = rdata_q;
        if (enter_resp) begin
            if (acc_wr || drop) begin
                rdata_d = 16'h0000;
            end else if (acc_be) begin
                rdata_d = {{8{cur_byte[7]}}, cur_byte};
            end else begin
                rdata_d = cur_word;
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            be_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= enter_resp & mis;
            if (accept) begin
                wr_q    <= bus.write;
                be_q    <= bus.byte_en;
                addr_q  <= bus.address;
                wdata_q <= bus.write_data;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (commit_we) begin
            mem[mem_idx] <= new_word;
        end
    end

    // Outputs
    always_comb begin
        bus.ack          = (state_q == StResp);
        bus.busy         = (state_q != StIdle);
        bus.stall        = bus.req & ~bus.ack;
        bus.read_data    = rdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
        bus.misalign_err = err_q;
`endif
    end

`ifndef DMEM_MISALIGN_TRAP_EN
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench for dmem_responder against an array-based memory model.
// Honours DMEM_MISALIGN_TRAP_EN the same way as the design.
module tb_dmem_responder;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] model_mem [DEPTH];

    // Reference behaviour: returns the expected read_data and updates the model for stores.
    function automatic logic [15:0] model_access(input logic w, input logic be,
                                                 input logic [15:0] addr, input logic [15:0] wd,
                                                 output logic mis);
        int idx;
        int lane;
        logic [7:0] b;
        idx  = int'(addr) / 2;
        lane = int'(addr) % 2;
        mis  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (!be && lane == 1) begin
            mis = 1'b1;
            return 16'h0000;
        end
`endif
        if (idx >= int'(DEPTH)) return 16'h0000;
        if (w) begin
            if (be) model_mem[idx][lane*8 +: 8] = wd[7:0];
            else    model_mem[idx] = wd;
            return 16'h0000;
        end
        if (!be) return model_mem[idx];
        b = model_mem[idx][lane*8 +: 8];
        return {{8{b[7]}}, b};
    endfunction

    // Drives one access from a negedge; returns observations, ends at a negedge in idle.
    task automatic xfer(input logic w, input logic be, input logic [15:0] addr,
                        input logic [15:0] wd, output logic [15:0] rd, output int lat,
                        output bit side_ok, output logic mis, output bit tail_ok);
        bit seen;
        seen = 0; lat = 0; side_ok = 1; rd = 16'h0000; mis = 1'b0;
        bus.req = 1'b1; bus.write = w; bus.byte_en = be;
        bus.address = addr; bus.write_data = wd;
        while (!seen && lat < 20) begin
            @(posedge clock); @(negedge clock);
            lat++;
            if (bus.ack === 1'b1) begin
                seen = 1;
                rd   = bus.read_data;
                if (bus.stall !== 1'b0) side_ok = 0;
`ifdef DMEM_MISALIGN_TRAP_EN
                mis = bus.misalign_err;
`endif
            end else begin
                if (bus.stall !== 1'b1 || bus.busy !== 1'b1) side_ok = 0;
`ifdef DMEM_MISALIGN_TRAP_EN
                if (bus.misalign_err !== 1'b0) side_ok = 0;
`endif
                // Scramble inputs; the in-flight access must ignore them.
                bus.write      = 1'($urandom);
                bus.byte_en    = 1'($urandom);
                bus.address    = 16'($urandom);
                bus.write_data = 16'($urandom);
            end
        end
        if (!seen) lat = -1;
        bus.req = 1'b0;
        @(posedge clock); @(negedge clock);
        tail_ok = (bus.ack === 1'b0) && (bus.busy === 1'b0) && (bus.stall === 1'b0);
    endtask

    task automatic test_reset();
        bus.req = 1'b1; bus.write = 1'b0; bus.byte_en = 1'b0;
        bus.address = 16'h0000; bus.write_data = 16'h0000;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_cmp++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b required 0", bus.ack); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        n_cmp++; if (bus.read_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h required 0000", bus.read_data); end
        n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b required 1", bus.stall); end
`ifdef DMEM_MISALIGN_TRAP_EN
        n_cmp++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b required 0", bus.misalign_err); end
`endif
        bus.req = 1'b0;
        reset = 1'b0;
        @(posedge clock); @(negedge clock);
    endtask

    task automatic test_word_basic();
        logic [15:0] rd; int lat; bit s_ok, t_ok; logic mis, mis_e, dummy;
        dummy = model_access(1'b1, 1'b0, 16'h0010, 16'hBEEF, mis_e);
        xfer(1'b1, 1'b0, 16'h0010, 16'hBEEF, rd, lat, s_ok, mis, t_ok);
        n_cmp++; if (lat != int'(LAT)) begin n_fail++; $display("FAIL basic_store_lat: got %0d required %0d", lat, LAT); end
        n_cmp++; if (!s_ok || !t_ok) begin n_fail++; $display("FAIL basic_store_handshake: got side=%0b tail=%0b required 1/1", s_ok, t_ok); end
        n_cmp++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL basic_store_rdata: got %h required 0000", rd); end
        dummy = model_access(1'b0, 1'b0, 16'h0010, 16'h0000, mis_e);
        xfer(1'b0, 1'b0, 16'h0010, 16'h0000, rd, lat, s_ok, mis, t_ok);
        n_cmp++; if (lat != int'(LAT)) begin n_fail++; $display("FAIL basic_load_lat: got %0d required %0d", lat, LAT); end
        n_cmp++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL basic_load_rdata: got %h required beef", rd); end
    endtask

    task automatic test_fill();
        logic [15:0] rd, wd, exp; int lat; bit s_ok, t_ok; logic mis, mis_e;
        for (int i = 0; i < int'(DEPTH); i++) begin
            wd  = 16'($urandom);
            exp = model_access(1'b1, 1'b0, 16'(2 * i), wd, mis_e);
            xfer(1'b1, 1'b0, 16'(2 * i), wd, rd, lat, s_ok, mis, t_ok);
            n_cmp++;
            if (lat != int'(LAT) || !s_ok || !t_ok || rd !== exp) begin
                n_fail++;
                $display("FAIL fill[%0d]: got lat=%0d side=%0b tail=%0b rd=%h required lat=%0d 1/1 rd=%h",
                         i, lat, s_ok, t_ok, rd, LAT, exp);
            end
        end
    endtask

    task automatic test_byte_lanes();
        logic [15:0] rd, exp; int lat; bit s_ok, t_ok; logic mis, mis_e;
        logic [15:0] req_a [5] = '{16'h0010, 16'h0011, 16'h0010, 16'h0011, 16'h0010};
        logic        req_w [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        req_b [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [15:0] req_d [5] = '{16'h1234, 16'hA580, 16'h0000, 16'h0000, 16'h0000};
        logic [15:0] want  [5] = '{16'h0000, 16'h0000, 16'h8034, 16'hFF80, 16'h0034};
        for (int i = 0; i < 5; i++) begin
            exp = model_access(req_w[i], req_b[i], req_a[i], req_d[i], mis_e);
            xfer(req_w[i], req_b[i], req_a[i], req_d[i], rd, lat, s_ok, mis, t_ok);
            n_cmp++;
            if (rd !== want[i] || exp !== want[i] || lat != int'(LAT)) begin
                n_fail++;
                $display("FAIL byte_lanes[%0d]: got rd=%h lat=%0d required rd=%h lat=%0d",
                         i, rd, lat, want[i], LAT);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] rd, exp, a, wd; logic w, be; int lat; bit s_ok, t_ok; logic mis, mis_e;
        for (int i = 0; i < 150; i++) begin
            w  = 1'($urandom);
            be = 1'($urandom);
            wd = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(16'h0200, 16'hFFFF));
            else                           a = 16'($urandom_range(0, 511));
            exp = model_access(w, be, a, wd, mis_e);
            xfer(w, be, a, wd, rd, lat, s_ok, mis, t_ok);
            n_cmp++;
            if (rd !== exp || mis !== mis_e || lat != int'(LAT) || !s_ok || !t_ok) begin
                n_fail++;
                $display("FAIL random[%0d] w=%0b be=%0b a=%h: got rd=%h mis=%0b lat=%0d side=%0b tail=%0b required rd=%h mis=%0b lat=%0d",
                         i, w, be, a, rd, mis, lat, s_ok, t_ok, exp, mis_e, LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [6];
        logic [15:0] exps  [6];
        logic mis_e, prev_ack;
        int k, first, last, busy_low, gap_bad, wide_bad;
        for (int i = 0; i < 6; i++) begin
            addrs[i] = 16'($urandom_range(0, 255)) << 1;
            exps[i]  = model_access(1'b0, 1'b0, addrs[i], 16'h0000, mis_e);
        end
        k = 0; first = -1; last = -1; busy_low = 0; gap_bad = 0; wide_bad = 0; prev_ack = 1'b0;
        bus.req = 1'b1; bus.write = 1'b0; bus.byte_en = 1'b0; bus.address = addrs[0];
        for (int c = 0; c < 22; c++) begin
            @(posedge clock); @(negedge clock);
            if (bus.ack === 1'b1) begin
                if (prev_ack) wide_bad++;
                if (k < 6) begin
                    n_cmp++;
                    if (bus.read_data !== exps[k]) begin
                        n_fail++;
                        $display("FAIL b2b_rdata[%0d]: got %h required %h", k, bus.read_data, exps[k]);
                    end
                end
                if (last >= 0 && c - last != int'(LAT) + 1) gap_bad++;
                if (first < 0) first = c;
                last = c;
                k++;
                if (k < 6) bus.address = addrs[k];
                else       bus.req = 1'b0;
            end else if (first >= 0 && k < 6 && bus.busy === 1'b0) begin
                busy_low++;
            end
            prev_ack = bus.ack;
        end
        n_cmp++; if (k != 6) begin n_fail++; $display("FAIL b2b_count: got %0d acks required 6", k); end
        n_cmp++; if (first != int'(LAT) - 1) begin n_fail++; $display("FAIL b2b_first: got cycle %0d required %0d", first, LAT - 1); end
        n_cmp++; if (gap_bad != 0) begin n_fail++; $display("FAIL b2b_spacing: got %0d bad gaps required 0", gap_bad); end
        n_cmp++; if (wide_bad != 0) begin n_fail++; $display("FAIL b2b_ack_width: got %0d wide acks required 0", wide_bad); end
        n_cmp++; if (busy_low != 5) begin n_fail++; $display("FAIL b2b_busy_low: got %0d required 5", busy_low); end
    endtask

    task automatic test_out_of_range();
        logic [15:0] rd, exp; int lat; bit s_ok, t_ok; logic mis, mis_e;
        exp = model_access(1'b1, 1'b0, 16'hFFFE, 16'h5A5A, mis_e);
        xfer(1'b1, 1'b0, 16'hFFFE, 16'h5A5A, rd, lat, s_ok, mis, t_ok);
        n_cmp++; if (lat != int'(LAT) || rd !== 16'h0000) begin n_fail++; $display("FAIL oor_store: got lat=%0d rd=%h required lat=%0d rd=0000", lat, rd, LAT); end
        exp = model_access(1'b0, 1'b0, 16'hFFFE, 16'h0000, mis_e);
        xfer(1'b0, 1'b0, 16'hFFFE, 16'h0000, rd, lat, s_ok, mis, t_ok);
        n_cmp++; if (rd !== 16'h0000 || lat != int'(LAT)) begin n_fail++; $display("FAIL oor_load: got lat=%0d rd=%h required lat=%0d rd=0000", lat, rd, LAT); end
        for (int i = 0; i < int'(DEPTH); i++) begin
            exp = model_access(1'b0, 1'b0, 16'(2 * i), 16'h0000, mis_e);
            xfer(1'b0, 1'b0, 16'(2 * i), 16'h0000, rd, lat, s_ok, mis, t_ok);
            n_cmp++;
            if (rd !== exp) begin n_fail++; $display("FAIL oor_array[%0d]: got %h required %h", i, rd, exp); end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd, exp; int lat; bit s_ok, t_ok, ack_seen; logic mis, mis_e;
        exp = model_access(1'b1, 1'b0, 16'h0004, 16'hA0A0, mis_e);
        xfer(1'b1, 1'b0, 16'h0004, 16'hA0A0, rd, lat, s_ok, mis, t_ok);
        exp = model_access(1'b0, 1'b0, 16'h0008, 16'h0000, mis_e);
        xfer(1'b0, 1'b0, 16'h0008, 16'h0000, rd, lat, s_ok, mis, t_ok);
        bus.req = 1'b1; bus.write = 1'b1; bus.byte_en = 1'b0;
        bus.address = 16'h0004; bus.write_data = 16'h5555;
        @(posedge clock); @(negedge clock);
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_wait: got %b required 1", bus.busy); end
        reset = 1'b1; bus.req = 1'b0;
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        ack_seen = 0;
        n_cmp++; if (bus.busy !== 1'b0 || bus.read_data !== 16'h0000) begin n_fail++; $display("FAIL rmid_idle: got busy=%b rd=%h required busy=0 rd=0000", bus.busy, bus.read_data); end
        for (int c = 0; c < 4; c++) begin
            if (bus.ack !== 1'b0) ack_seen = 1;
            @(posedge clock); @(negedge clock);
        end
        n_cmp++; if (ack_seen) begin n_fail++; $display("FAIL rmid_ack: got ack pulse required none"); end
        exp = model_access(1'b0, 1'b0, 16'h0004, 16'h0000, mis_e);
        xfer(1'b0, 1'b0, 16'h0004, 16'h0000, rd, lat, s_ok, mis, t_ok);
        n_cmp++; if (rd !== 16'hA0A0 || exp !== 16'hA0A0) begin n_fail++; $display("FAIL rmid_load: got %h required a0a0", rd); end
    endtask

    task automatic test_misalign();
        logic [15:0] rd, exp, wd; int lat; bit s_ok, t_ok; logic mis, mis_e, dummy;
        wd  = 16'($urandom) | 16'h0101;
        exp = model_access(1'b1, 1'b0, 16'h0003, wd, mis_e);
        xfer(1'b1, 1'b0, 16'h0003, wd, rd, lat, s_ok, mis, t_ok);
        n_cmp++; if (mis !== mis_e || rd !== exp) begin n_fail++; $display("FAIL mis_store: got mis=%b rd=%h required mis=%b rd=%h", mis, rd, mis_e, exp); end
        n_cmp++; if (lat != int'(LAT) || !s_ok || !t_ok) begin n_fail++; $display("FAIL mis_timing: got lat=%0d side=%0b tail=%0b required %0d 1/1", lat, s_ok, t_ok, LAT); end
        exp = model_access(1'b0, 1'b0, 16'h0002, 16'h0000, dummy);
        xfer(1'b0, 1'b0, 16'h0002, 16'h0000, rd, lat, s_ok, mis, t_ok);
        n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL mis_word1: got %h required %h", rd, exp); end
    endtask

    initial begin
        test_reset();
        test_word_basic();
        test_fill();
        test_byte_lanes();
        test_random();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder. It serves the CPU's MEM-stage load/store requests over a req/ack handshake.
- Owns a word-organised 16-bit storage array and supports word and byte accesses.
- Drives a stall signal that the hazard unit uses to freeze the pipeline while an access is outstanding.
- Sits between the EX/MEM buffer outputs and the MEM/WB buffer inputs. It is the responding end of the CPU's data-memory interface.

Parameters:
- DEPTH_WORDS, 256, number of 16-bit words in storage; valid word index is 0..DEPTH_WORDS-1.
- LATENCY, 2, cycles from the accept edge to ack (must be >= 1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  initiator request; held high until ack is seen.
- write  in  1  1 = store, 0 = load; sampled at accept.
- byte_en  in  1  1 = byte access, 0 = word access; sampled at accept.
- address  in  16  byte address; sampled at accept.
- write_data  in  16  store data (byte stores use [7:0]); sampled at accept.
- read_data  out  16  load result; valid only while ack = 1.
- ack  out  1  one-cycle completion pulse.
- stall  out  1  combinational req & ~ack; drives pipeline hold.
- busy  out  1  high in WAIT and RESP.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset drives state = IDLE, ack = 0, read_data = 0, busy = 0, and clears the internal counter and captured fields.
  - Storage contents are not altered by reset.
- States:
  - IDLE: with req = 1 at the rising edge, capture write, byte_en, address and write_data (the accept edge). Go to WAIT with cnt = LATENCY-1, or straight to RESP if LATENCY = 1.
  - WAIT: cnt decrements each cycle. On the edge where cnt = 1, go to RESP.
  - RESP: ack = 1 for exactly one cycle. On the next edge, unconditionally return to IDLE.
  - ack rises exactly LATENCY cycles after the accept edge.
  - A back-to-back request is accepted on the edge after leaving RESP. Maximum throughput is one access per LATENCY+1 cycles.
- Commit and read timing:
  - Stores commit to storage on the edge that enters RESP.
  - read_data is registered on that same edge, so a load issued after a store to the same address returns the new value.
- Addressing and data layout:
  - Word index = address[15:1].
  - Word access ignores address[0].
  - Little-endian byte lanes: address[0] = 0 selects bits [7:0], address[0] = 1 selects bits [15:8].
  - Byte load returns the selected byte sign-extended to 16 bits.
  - Byte store modifies only the selected lane and leaves the other lane unchanged.
  - Word store writes all 16 bits.
- Store responses: read_data in RESP is 0.
- Out-of-range access (word index >= DEPTH_WORDS):
  - Stores are dropped; no storage changes.
  - Loads return 0.
  - ack still pulses normally.
- req deasserted mid-transaction: the transaction still completes (store commits, ack pulses). The initiator ignores the stray ack.
- Input changes after the accept edge have no effect on the in-flight access.
- Reset mid-transaction:
  - Aborts the access and returns to IDLE.
  - A store whose commit edge has not yet occurred is not written.
  - If reset and the commit edge coincide, reset wins (no write).
- req asserted while busy: ignored until IDLE. stall remains high.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_err (1 bit, reset 0).
  - A word access with address[0] = 1 is flagged at accept.
  - In RESP it pulses misalign_err together with ack; the store is suppressed and read_data = 0.
- Not defined:
  - The port is absent.
  - Odd-address word accesses silently use address[15:1].

Test Plan:
- Reset, then word store 16'hBEEF to address 0x0010, LATENCY = 2: ack on the 2nd cycle after the accept edge, stall high until then. A following word load of 0x0010 returns 16'hBEEF with ack.
- Byte store 8'h80 to 0x0011 over word 16'h1234: word load gives 16'h8034. Byte load of 0x0011 gives 16'hFF80. Byte load of 0x0010 gives 16'h0034.
- Back-to-back loads with req held high: accepts occur every LATENCY+1 cycles. ack is one cycle wide. busy falls exactly one cycle per transaction.
- Word store to address 16'hFFFE with DEPTH_WORDS = 256: ack pulses, no storage word changes (full-array compare), and a subsequent load of it returns 0.
- Assert reset in WAIT during a store of 16'h5555 to 0x0004: ack never pulses, state is IDLE. A later load of 0x0004 returns the prior value.
- With DMEM_MISALIGN_TRAP_EN, word store to 0x0003: misalign_err and ack pulse together and word 1 is unchanged. Without the macro, the store writes word 1.
